// File: rtl/axi_wr_burst_feed.sv
// Stream-to-burst feeder: buffers a valid/ready stream in a FWFT FIFO and issues
// linear, region-wrapping write bursts. Define AXI_WR_BURST_FLUSH_EN to enable partial-burst flush.
module axi_wr_burst_feed #(
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    BURST_LEN    = 16,
    parameter int                    FIFO_DEPTH   = 64,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
    parameter logic [ADDR_WIDTH-1:0] REGION_BYTES = ADDR_WIDTH'(32'h0010_0000),
    parameter int                    RESP_GAP     = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         s_valid,
    input  logic [DATA_WIDTH-1:0]        s_data,
    output logic                         s_ready,
    input  logic                         flush,
    output logic                         wr_start,
    output logic [ADDR_WIDTH-1:0]        wr_addr,
    output logic [7:0]                   wr_len,
    output logic [DATA_WIDTH-1:0]        wr_data,
    input  logic                         wr_ready,
    input  logic                         wr_done,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
    output logic                         busy,
    output logic                         wrap
);

    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int LVL_W      = PTR_W + 1;
    localparam int BYTE_SHIFT = $clog2(DATA_WIDTH / 8);

    localparam logic [LVL_W-1:0]    BURST_LVL  = LVL_W'(BURST_LEN);
    localparam logic [LVL_W-1:0]    DEPTH_LVL  = LVL_W'(FIFO_DEPTH);
    localparam logic [8:0]          BURST_LEN9 = 9'(BURST_LEN);
    localparam logic [7:0]          GAP_LAST   = 8'(RESP_GAP - 1);
    localparam logic [ADDR_WIDTH:0] REGION_END = {1'b0, BASE_ADDR} + {1'b0, REGION_BYTES};

    typedef enum logic [1:0] {IDLE, START, DATA, GAP} state_t;

    state_t                  state_reg, state_next;
    logic [DATA_WIDTH-1:0]   mem_reg [FIFO_DEPTH];
    logic [PTR_W-1:0]        wptr_reg, wptr_next;
    logic [PTR_W-1:0]        rptr_reg, rptr_next;
    logic [LVL_W-1:0]        level_reg, level_next;
    logic                    ready_reg, ready_next;
    logic [8:0]              len_reg, len_next;
    logic [8:0]              beat_reg, beat_next;
    logic [7:0]              gap_reg, gap_next;
    logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
    logic                    wrap_pend_reg, wrap_pend_next;
    logic [ADDR_WIDTH:0]     next_sum;
    logic                    wrap_now;
    logic                    push;
    logic                    pop;

`ifdef AXI_WR_BURST_FLUSH_EN
    logic                    flush_pend_reg, flush_pend_next;
`else
    logic                    unused_flush;
    assign unused_flush = flush;
`endif

    assign push = s_valid && ready_reg;
    // Beats beyond the latched length are dropped so a misbehaving master cannot eat the next burst.
    assign pop  = (state_reg == DATA) && wr_ready && (beat_reg < len_reg) && (level_reg != '0);

    assign next_sum = {1'b0, addr_reg} + ((ADDR_WIDTH+1)'(len_reg) << BYTE_SHIFT);
    assign wrap_now = (next_sum >= REGION_END);

    always_comb begin
        level_next = level_reg;
        case ({push, pop})
            2'b10:   level_next = level_reg + LVL_W'(1);
            2'b01:   level_next = level_reg - LVL_W'(1);
            default: level_next = level_reg;
        endcase
        ready_next = (level_next != DEPTH_LVL);
        wptr_next  = push ? wptr_reg + PTR_W'(1) : wptr_reg;
        rptr_next  = pop  ? rptr_reg + PTR_W'(1) : rptr_reg;
    end

    always_comb begin
        state_next     = state_reg;
        len_next       = len_reg;
        beat_next      = beat_reg;
        gap_next       = gap_reg;
        addr_next      = addr_reg;
        wrap_pend_next = wrap_pend_reg;
`ifdef AXI_WR_BURST_FLUSH_EN
        flush_pend_next = flush_pend_reg;
`endif
        case (state_reg)
            IDLE: begin
                beat_next = '0;
                if (level_reg >= BURST_LVL) begin
                    state_next = START;
                    len_next   = BURST_LEN9;
                end
`ifdef AXI_WR_BURST_FLUSH_EN
                else if (flush_pend_reg && (level_reg != '0)) begin
                    state_next = START;
                    len_next   = 9'(level_reg);
                end else if (flush_pend_reg) begin
                    flush_pend_next = 1'b0;
                end
`endif
            end
            START: begin
                state_next     = DATA;
                beat_next      = '0;
                addr_next      = wrap_now ? BASE_ADDR : next_sum[ADDR_WIDTH-1:0];
                // The wrap is reported with the start of the burst that lands on BASE_ADDR.
                wrap_pend_next = wrap_now;
`ifdef AXI_WR_BURST_FLUSH_EN
                if (len_reg != BURST_LEN9) begin
                    flush_pend_next = 1'b0;
                end
`endif
            end
            DATA: begin
                if (pop) begin
                    beat_next = beat_reg + 9'd1;
                end
                if (wr_done) begin
                    state_next = GAP;
                    gap_next   = '0;
                end
            end
            GAP: begin
                if (gap_reg == GAP_LAST) begin
                    state_next = IDLE;
                end else begin
                    gap_next = gap_reg + 8'd1;
                end
            end
            default: state_next = IDLE;
        endcase
`ifdef AXI_WR_BURST_FLUSH_EN
        if (flush) begin
            flush_pend_next = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (push) begin
            mem_reg[wptr_reg] <= s_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_reg      <= '0;
            rptr_reg      <= '0;
            level_reg     <= '0;
            ready_reg     <= 1'b0;
            len_reg       <= BURST_LEN9;
            beat_reg      <= '0;
            gap_reg       <= '0;
            addr_reg      <= BASE_ADDR;
            wrap_pend_reg <= 1'b0;
        end else begin
            wptr_reg      <= wptr_next;
            rptr_reg      <= rptr_next;
            level_reg     <= level_next;
            ready_reg     <= ready_next;
            len_reg       <= len_next;
            beat_reg      <= beat_next;
            gap_reg       <= gap_next;
            addr_reg      <= addr_next;
            wrap_pend_reg <= wrap_pend_next;
        end
    end

`ifdef AXI_WR_BURST_FLUSH_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_pend_reg <= 1'b0;
        end else begin
            flush_pend_reg <= flush_pend_next;
        end
    end
`endif

    assign s_ready    = ready_reg;
    assign wr_start   = (state_reg == START);
    assign wr_addr    = addr_reg;
    assign wr_len     = len_reg[7:0];
    assign wr_data    = mem_reg[rptr_reg];
    assign fifo_level = level_reg;
    assign busy       = (state_reg != IDLE);
    assign wrap       = (state_reg == START) && wrap_pend_reg;

    wr_ready_overrun: assert property (@(posedge clk) disable iff (rst)
        !((state_reg == DATA) && wr_ready && (beat_reg >= len_reg)))
        else $error("wr_ready beyond burst length");

endmodule

// File: tb/tb_axi_wr_burst_feed.sv
// Bench for axi_wr_burst_feed: table of burst scenarios plus hand sequences for latency,
// mid-burst reset and flush; a write-master model checks beat data against a scoreboard queue.
module tb_axi_wr_burst_feed;

    logic        clk;
    logic        rst;
    logic        s_valid;
    logic [31:0] s_data;
    logic        s_ready;
    logic        flush;
    logic        wr_start;
    logic [31:0] wr_addr;
    logic [7:0]  wr_len;
    logic [31:0] wr_data;
    logic        wr_ready;
    logic        wr_done;
    logic [6:0]  fifo_level;
    logic        busy;
    logic        wrap;

    axi_wr_burst_feed #(
        .ADDR_WIDTH   (32),
        .DATA_WIDTH   (32),
        .BURST_LEN    (16),
        .FIFO_DEPTH   (64),
        .BASE_ADDR    (32'h0),
        .REGION_BYTES (32'h80),
        .RESP_GAP     (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .flush      (flush),
        .wr_start   (wr_start),
        .wr_addr    (wr_addr),
        .wr_len     (wr_len),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .wr_done    (wr_done),
        .fifo_level (fifo_level),
        .busy       (busy),
        .wrap       (wrap)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  len;
        logic        wrp;
    } burst_t;

    typedef struct {
        int              n_push;
        bit              stall;
        int              n_bursts;
        logic [3:0][31:0] addr;
        logic [3:0][7:0]  len;
        logic [3:0]       wrp;
        int              level;
    } vec_t;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_q [$];
    burst_t      burst_q [$];
    bit          stall = 1'b0;
    int          m_left = 0;
    int          m_beats = 0;
    vec_t        vecs [4];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "bench timeout");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Write-master model: accepts each burst at full rate unless stalled, checking every beat.
    initial begin
        logic [31:0] e;
        wr_ready = 1'b0;
        wr_done  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_left   = 0;
                m_beats  = 0;
                wr_ready = 1'b0;
                wr_done  = 1'b0;
            end else begin
                if (m_left > 0 && !stall) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL beat_data: got 0x%0h, required none (scoreboard empty)", wr_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat_data", 64'(wr_data), 64'(e));
                    end
                    wr_ready = 1'b1;
                    m_left--;
                    m_beats++;
                    wr_done = (m_left == 0);
                end else begin
                    wr_ready = 1'b0;
                    wr_done  = 1'b0;
                end
                if (wr_start === 1'b1) begin
                    burst_q.push_back('{wr_addr, wr_len, wrap});
                    m_left = (wr_len == 8'd0) ? 256 : int'(wr_len);
                    $display("burst addr=0x%0h len=%0d wrap=%0b", wr_addr, wr_len, wrap);
                end
            end
        end
    end

    task automatic push_word(input logic [31:0] d);
        int t = 0;
        while (s_ready !== 1'b1 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (s_ready !== 1'b1) begin
            n_vec++;
            n_err++;
            $display("FAIL push_timeout: s_ready=%b, required 1", s_ready);
        end else begin
            s_valid = 1'b1;
            s_data  = d;
            exp_q.push_back(d);
            @(negedge clk);
            s_valid = 1'b0;
        end
    endtask

    task automatic do_reset(input bit chk);
        rst     = 1'b1;
        s_valid = 1'b0;
        flush   = 1'b0;
        stall   = 1'b0;
        @(negedge clk);
        if (chk) begin
            check("rst_s_ready",    64'(s_ready),    64'd0);
            check("rst_wr_start",   64'(wr_start),   64'd0);
            check("rst_wr_addr",    64'(wr_addr),    64'd0);
            check("rst_wr_len",     64'(wr_len),     64'd16);
            check("rst_wr_data",    64'(wr_data),    64'd0);
            check("rst_fifo_level", 64'(fifo_level), 64'd0);
            check("rst_busy",       64'(busy),       64'd0);
            check("rst_wrap",       64'(wrap),       64'd0);
        end
        exp_q.delete();
        burst_q.delete();
        rst = 1'b0;
        @(negedge clk);
        if (chk) begin
            check("s_ready_after_rst", 64'(s_ready), 64'd1);
        end
    endtask

    task automatic wait_quiet();
        int t = 0;
        while (!(busy == 1'b0 && fifo_level < 7'd16 && m_left == 0) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("quiet_within_budget", 64'(t < 3000), 64'd1);
        repeat (20) @(negedge clk);
    endtask

    initial begin
        int t;
        rst      = 1'b1;
        s_valid  = 1'b0;
        s_data   = '0;
        flush    = 1'b0;

        // addr/len/wrp are packed: element [0] is the rightmost field.
        vecs[0] = '{32, 1'b0, 2, {32'h0, 32'h0, 32'h40, 32'h0}, {8'd16, 8'd16, 8'd16, 8'd16}, 4'b0000, 0};
        vecs[1] = '{40, 1'b0, 2, {32'h0, 32'h0, 32'h40, 32'h0}, {8'd16, 8'd16, 8'd16, 8'd16}, 4'b0000, 8};
        vecs[2] = '{48, 1'b0, 3, {32'h0, 32'h0, 32'h40, 32'h0}, {8'd16, 8'd16, 8'd16, 8'd16}, 4'b0100, 0};
        vecs[3] = '{64, 1'b1, 4, {32'h40, 32'h0, 32'h40, 32'h0}, {8'd16, 8'd16, 8'd16, 8'd16}, 4'b0100, 0};

        do_reset(1'b1);

        for (int v = 0; v < 4; v++) begin
            do_reset(1'b0);
            stall = vecs[v].stall;
            for (int i = 0; i < vecs[v].n_push; i++) begin
                push_word(32'((v << 8) + i + 1));
            end
            if (vecs[v].stall) begin
                check("stall_level",   64'(fifo_level), 64'd64);
                check("stall_s_ready", 64'(s_ready),    64'd0);
                stall = 1'b0;
            end
            wait_quiet();
            check("n_bursts", 64'(burst_q.size()), 64'(vecs[v].n_bursts));
            for (int j = 0; j < vecs[v].n_bursts && j < burst_q.size(); j++) begin
                check("burst_addr", 64'(burst_q[j].addr), 64'(vecs[v].addr[j]));
                check("burst_len",  64'(burst_q[j].len),  64'(vecs[v].len[j]));
                check("burst_wrap", 64'(burst_q[j].wrp),  64'(vecs[v].wrp[j]));
            end
            check("end_level",     64'(fifo_level),    64'(vecs[v].level));
            check("end_busy",      64'(busy),          64'd0);
            check("fifo_contents", 64'(exp_q.size()),  64'(vecs[v].level));
        end

        // Start latency: the 16th push edge N gives wr_start seen at edge N+2.
        do_reset(1'b0);
        for (int i = 0; i < 16; i++) begin
            push_word(32'h0A00 + 32'(i));
        end
        check("lat_start_early", 64'(wr_start),   64'd0);
        check("lat_level",       64'(fifo_level), 64'd16);
        @(negedge clk);
        check("lat_start",       64'(wr_start),   64'd1);
        check("lat_addr",        64'(wr_addr),    64'd0);
        check("lat_len",         64'(wr_len),     64'd16);
        check("lat_busy",        64'(busy),       64'd1);
        wait_quiet();
        check("lat_n_bursts",    64'(burst_q.size()), 64'd1);

        // Reset after 7 accepted beats, then refill.
        do_reset(1'b0);
        for (int i = 0; i < 16; i++) begin
            push_word(32'h0B00 + 32'(i));
        end
        t = 0;
        while (m_beats < 7 && t < 500) begin
            @(posedge clk);
            t++;
        end
        check("midrst_reached_beat7", 64'(m_beats >= 7), 64'd1);
        #1;
        do_reset(1'b1);
        for (int i = 0; i < 16; i++) begin
            push_word(32'h0B80 + 32'(i));
        end
        wait_quiet();
        check("midrst_n_bursts", 64'(burst_q.size()), 64'd1);
        if (burst_q.size() > 0) begin
            check("midrst_addr", 64'(burst_q[0].addr), 64'd0);
        end
        check("midrst_level", 64'(fifo_level), 64'd0);

        // Flush of a partial FIFO.
        do_reset(1'b0);
        for (int i = 0; i < 5; i++) begin
            push_word(32'h0C00 + 32'(i));
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        repeat (3) @(negedge clk);
        wait_quiet();
`ifdef AXI_WR_BURST_FLUSH_EN
        check("flush_n_bursts", 64'(burst_q.size()), 64'd1);
        if (burst_q.size() > 0) begin
            check("flush_addr", 64'(burst_q[0].addr), 64'd0);
            check("flush_len",  64'(burst_q[0].len),  64'd5);
        end
        check("flush_level", 64'(fifo_level), 64'd0);
        for (int i = 0; i < 16; i++) begin
            push_word(32'h0C80 + 32'(i));
        end
        wait_quiet();
        check("flush_next_n_bursts", 64'(burst_q.size()), 64'd2);
        if (burst_q.size() > 1) begin
            check("flush_next_addr", 64'(burst_q[1].addr), 64'h14);
            check("flush_next_len",  64'(burst_q[1].len),  64'd16);
        end
`else
        check("noflush_n_bursts", 64'(burst_q.size()), 64'd0);
        check("noflush_level",    64'(fifo_level),     64'd5);
        for (int i = 0; i < 11; i++) begin
            push_word(32'h0C80 + 32'(i));
        end
        wait_quiet();
        check("noflush_full_n_bursts", 64'(burst_q.size()), 64'd1);
        if (burst_q.size() > 0) begin
            check("noflush_full_addr", 64'(burst_q[0].addr), 64'd0);
            check("noflush_full_len",  64'(burst_q[0].len),  64'd16);
        end
        check("noflush_full_level", 64'(fifo_level), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
